// File: rtl/vpu_sram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// vpu_sram_rd_arbiter
//   Shares BANK_CNT single-read-port SRAM banks among N_REQ VPU operand read
//   ports. Each bank has its own round-robin arbiter. A grant locks the bank
//   to its owner until the owner's rlast beat, and the read data is routed
//   back to the owner one cycle after the beat.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_i         per-requester bank request, held until ack
//   rid_i         per-requester target bank index
//   addr_i        per-requester beat address
//   reb_i         per-requester beat strobe (active-low)
//   rlast_i       per-requester last-beat flag (qualified by reb_i=0)
//   ack_o         one-cycle grant pulse per requester
//   rdata_o       per-requester returned read data (held while rvalid_o=0)
//   rvalid_o      per-requester return valid
//   bank_reb_o    per-bank read strobe (active-low)
//   bank_addr_o   per-bank read address
//   bank_rdata_i  per-bank read data, valid one cycle after bank_reb_o=0
// ---------------------------------------------------------------------------
module vpu_sram_rd_arbiter #(
  parameter int N_REQ     = 3,
  parameter int BANK_CNT  = 4,
  parameter int DEPTH_LG2 = 10,
  parameter int DATA_W    = 256,
  localparam int BANK_LG2 = (BANK_CNT > 1) ? $clog2(BANK_CNT) : 1,
  localparam int OWN_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ*BANK_LG2-1:0]     rid_i,
  input  logic [N_REQ*DEPTH_LG2-1:0]    addr_i,
  input  logic [N_REQ-1:0]              reb_i,
  input  logic [N_REQ-1:0]              rlast_i,
  output logic [N_REQ-1:0]              ack_o,
  output logic [N_REQ*DATA_W-1:0]       rdata_o,
  output logic [N_REQ-1:0]              rvalid_o,
  output logic [BANK_CNT-1:0]           bank_reb_o,
  output logic [BANK_CNT*DEPTH_LG2-1:0] bank_addr_o,
  input  logic [BANK_CNT*DATA_W-1:0]    bank_rdata_i
);

  logic [BANK_CNT-1:0] locked_q, locked_d;
  logic [OWN_W-1:0]    owner_q  [BANK_CNT];
  logic [OWN_W-1:0]    owner_d  [BANK_CNT];
  logic [OWN_W-1:0]    rr_q     [BANK_CNT];
  logic [OWN_W-1:0]    rr_d     [BANK_CNT];
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [BANK_CNT-1:0] ret_vld_q, ret_vld_d;
  logic [OWN_W-1:0]    ret_own_q [BANK_CNT];
  logic [DATA_W-1:0]   rdata_q   [N_REQ];

  logic [N_REQ-1:0]    owns;
  logic [BANK_CNT-1:0] beat, last;
  logic [BANK_CNT-1:0] grant_vld;
  logic [OWN_W-1:0]    grant_idx [BANK_CNT];

  // A requester already holding a bank may not compete for another one.
  always_comb begin
    owns = '0;
    for (int b = 0; b < BANK_CNT; b++)
      for (int r = 0; r < N_REQ; r++)
        if (locked_q[b] && owner_q[b] == OWN_W'(r)) owns[r] = 1'b1;
  end

  // Owner beat pass-through: strobe and address reach the bank the same cycle.
  always_comb begin
    bank_reb_o  = '1;
    bank_addr_o = '0;
    beat        = '0;
    last        = '0;
    for (int b = 0; b < BANK_CNT; b++)
      for (int r = 0; r < N_REQ; r++)
        if (locked_q[b] && owner_q[b] == OWN_W'(r) && !reb_i[r]) begin
          beat[b]       = 1'b1;
          last[b]       = rlast_i[r];
          bank_reb_o[b] = 1'b0;
          bank_addr_o[b*DEPTH_LG2 +: DEPTH_LG2] = addr_i[r*DEPTH_LG2 +: DEPTH_LG2];
        end
  end

  // Round-robin pick: scanning offsets high to low leaves the candidate
  // closest to rr_q (at or after it, wrapping) as the final winner.
  always_comb begin
    grant_vld = '0;
    for (int b = 0; b < BANK_CNT; b++) begin
      grant_idx[b] = '0;
      if (!locked_q[b])
        for (int i = N_REQ - 1; i >= 0; i--)
          for (int r = 0; r < N_REQ; r++)
            if (r == (int'(rr_q[b]) + i) % N_REQ && req_i[r] && !owns[r] &&
                rid_i[r*BANK_LG2 +: BANK_LG2] == BANK_LG2'(b)) begin
              grant_vld[b] = 1'b1;
              grant_idx[b] = OWN_W'(r);
            end
    end
  end

  always_comb begin
    locked_d  = locked_q;
    ack_d     = '0;
    ret_vld_d = beat;
    for (int b = 0; b < BANK_CNT; b++) begin
      owner_d[b] = owner_q[b];
      rr_d[b]    = rr_q[b];
      if (grant_vld[b]) begin
        locked_d[b] = 1'b1;
        owner_d[b]  = grant_idx[b];
        rr_d[b]     = OWN_W'((int'(grant_idx[b]) + 1) % N_REQ);
        for (int r = 0; r < N_REQ; r++)
          if (grant_idx[b] == OWN_W'(r)) ack_d[r] = 1'b1;
      end else if (beat[b] && last[b]) begin
        // Release on the last beat; arbitration resumes next cycle.
        locked_d[b] = 1'b0;
      end
    end
  end

  // Return routing: a requester owns at most one bank, so at most one bank
  // can target it in any cycle.
  always_comb begin
    rvalid_o = '0;
    for (int r = 0; r < N_REQ; r++) begin
      rdata_o[r*DATA_W +: DATA_W] = rdata_q[r];
      for (int b = 0; b < BANK_CNT; b++)
        if (ret_vld_q[b] && ret_own_q[b] == OWN_W'(r)) begin
          rvalid_o[r] = 1'b1;
          rdata_o[r*DATA_W +: DATA_W] = bank_rdata_i[b*DATA_W +: DATA_W];
        end
    end
  end

  assign ack_o = ack_q;

  // Stage boundary: bank request -> bank return.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q  <= '0;
      ack_q     <= '0;
      ret_vld_q <= '0;
      for (int b = 0; b < BANK_CNT; b++) begin
        owner_q[b]   <= '0;
        rr_q[b]      <= '0;
        ret_own_q[b] <= '0;
      end
      for (int r = 0; r < N_REQ; r++) rdata_q[r] <= '0;
    end else begin
      locked_q  <= locked_d;
      ack_q     <= ack_d;
      ret_vld_q <= ret_vld_d;
      for (int b = 0; b < BANK_CNT; b++) begin
        owner_q[b]   <= owner_d[b];
        rr_q[b]      <= rr_d[b];
        ret_own_q[b] <= owner_q[b];
      end
      for (int r = 0; r < N_REQ; r++) rdata_q[r] <= rdata_o[r*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_vpu_sram_rd_arbiter.sv
module tb_vpu_sram_rd_arbiter;
  localparam int N_REQ     = 3;
  localparam int BANK_CNT  = 4;
  localparam int DEPTH_LG2 = 10;
  localparam int DATA_W    = 256;
  localparam int BANK_LG2  = 2;

  logic                          clk;
  logic                          rst;
  logic [N_REQ-1:0]              req;
  logic [N_REQ*BANK_LG2-1:0]     rid;
  logic [N_REQ*DEPTH_LG2-1:0]    addr;
  logic [N_REQ-1:0]              reb;
  logic [N_REQ-1:0]              rlast;
  logic [N_REQ-1:0]              ack_o;
  logic [N_REQ*DATA_W-1:0]       rdata_o;
  logic [N_REQ-1:0]              rvalid_o;
  logic [BANK_CNT-1:0]           bank_reb_o;
  logic [BANK_CNT*DEPTH_LG2-1:0] bank_addr_o;
  logic [BANK_CNT*DATA_W-1:0]    bank_rdata;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int                r;
    int                cyc;
    logic [DATA_W-1:0] d;
  } exp_t;
  exp_t sb[$];

  vpu_sram_rd_arbiter #(
    .N_REQ(N_REQ), .BANK_CNT(BANK_CNT), .DEPTH_LG2(DEPTH_LG2), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .rid_i(rid), .addr_i(addr),
    .reb_i(reb), .rlast_i(rlast), .ack_o(ack_o), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .bank_reb_o(bank_reb_o), .bank_addr_o(bank_addr_o),
    .bank_rdata_i(bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank contents encode bank number and address so mis-routing is visible.
  function automatic logic [DATA_W-1:0] memval(input int b, input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(b << 12) | 32'(a);
    return {(DATA_W/32){w}};
  endfunction

  // SRAM bank model: data one cycle after a strobed read.
  always @(posedge clk)
    for (int b = 0; b < BANK_CNT; b++)
      if (!bank_reb_o[b])
        bank_rdata[b*DATA_W +: DATA_W] <= memval(b, int'(bank_addr_o[b*DEPTH_LG2 +: DEPTH_LG2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Return monitor: every rvalid_o must match the oldest expectation for
  // that requester, including the exact return cycle.
  always @(negedge clk) begin : mon
    int idx;
    for (int r = 0; r < N_REQ; r++) begin
      if (rvalid_o[r] === 1'b1) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].r == r) idx = i;
        checks++;
        assert (idx >= 0) else begin
          errors++;
          $error("FAIL unexpected_rvalid r%0d: observed=1 expected=0 cyc=%0d", r, cyc);
        end
        if (idx >= 0) begin
          checks++;
          assert (rdata_o[r*DATA_W +: DATA_W] === sb[idx].d && cyc === sb[idx].cyc) else begin
            errors++;
            $error("FAIL rdata r%0d: observed=%h@%0d expected=%h@%0d", r,
                   rdata_o[r*DATA_W +: DATA_W], cyc, sb[idx].d, sb[idx].cyc);
          end
          sb.delete(idx);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int r, input int b, input int a);
    exp_t e;
    e.r = r;
    e.cyc = cyc + 1;
    e.d = memval(b, a);
    sb.push_back(e);
  endtask

  task automatic request(input int r, input int b);
    req[r] = 1'b1;
    rid[r*BANK_LG2 +: BANK_LG2] = BANK_LG2'(b);
    @(negedge clk);
    chk("ack_early", 64'(ack_o[r]), 64'd0);
    tick();
    chk("ack", 64'(ack_o[r]), 64'd1);
    req[r] = 1'b0;
  endtask

  task automatic beat(input int r, input int b, input int a, input bit lst);
    reb[r] = 1'b0;
    addr[r*DEPTH_LG2 +: DEPTH_LG2] = DEPTH_LG2'(a);
    rlast[r] = lst;
    push_exp(r, b, a);
    @(negedge clk);
    chk("bank_reb", 64'(bank_reb_o[b]), 64'd0);
    chk("bank_addr", 64'(bank_addr_o[b*DEPTH_LG2 +: DEPTH_LG2]), 64'(a));
    tick();
    reb[r] = 1'b1;
    rlast[r] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; rid = '0; addr = '0; reb = '1; rlast = '0;
    bank_rdata = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_bank_reb", 64'(bank_reb_o), 64'hF);
    chk("rst_bank_addr", 64'(bank_addr_o), 64'd0);
    checks++;
    assert (rdata_o === '0) else begin
      errors++;
      $error("FAIL rst_rdata: observed=%h expected=0", rdata_o);
    end
    tick();
    rst = 1'b0;
    tick();

    // 1: single 4-beat burst on bank 2
    request(0, 2);
    for (int k = 0; k < 4; k++) beat(0, 2, 'h10 + k, k == 3);
    reb[0] = 1'b0;
    addr[0 +: DEPTH_LG2] = 10'h3AA;
    @(negedge clk);
    chk("t1_released", 64'(bank_reb_o[2]), 64'd1);
    tick();
    reb[0] = 1'b1;

    // 2: contention and round-robin on bank 1
    req[0] = 1'b1; rid[0 +: 2] = 2'd1;
    req[1] = 1'b1; rid[2 +: 2] = 2'd1;
    tick();
    chk("t2_ack0", 64'(ack_o[0]), 64'd1);
    chk("t2_ack1_lose", 64'(ack_o[1]), 64'd0);
    req[0] = 1'b0;
    beat(0, 1, 'h30, 1'b0);
    chk("t2_ack1_wait", 64'(ack_o[1]), 64'd0);
    beat(0, 1, 'h31, 1'b1);
    chk("t2_ack1_c1", 64'(ack_o[1]), 64'd0);
    tick();
    chk("t2_ack1_c2", 64'(ack_o[1]), 64'd1);
    req[1] = 1'b0;
    beat(1, 1, 'h32, 1'b1);
    req[0] = 1'b1; rid[0 +: 2] = 2'd1;
    req[2] = 1'b1; rid[4 +: 2] = 2'd1;
    tick();
    chk("t2_ack2_rr", 64'(ack_o[2]), 64'd1);
    chk("t2_ack0_rr", 64'(ack_o[0]), 64'd0);
    req[2] = 1'b0;
    beat(2, 1, 'h33, 1'b1);
    chk("t2_ack0_c1", 64'(ack_o[0]), 64'd0);
    tick();
    chk("t2_ack0_c2", 64'(ack_o[0]), 64'd1);
    req[0] = 1'b0;
    beat(0, 1, 'h34, 1'b1);

    // 3: independent banks granted together, concurrent bursts
    req[0] = 1'b1; rid[0 +: 2] = 2'd0;
    req[1] = 1'b1; rid[2 +: 2] = 2'd3;
    tick();
    chk("t3_ack", 64'(ack_o), 64'b011);
    req = '0;
    for (int k = 0; k < 2; k++) begin
      reb[0] = 1'b0; addr[0 +: 10]  = 10'('h40 + k); rlast[0] = (k == 1);
      reb[1] = 1'b0; addr[10 +: 10] = 10'('h50 + k); rlast[1] = (k == 1);
      push_exp(0, 0, 'h40 + k);
      push_exp(1, 3, 'h50 + k);
      @(negedge clk);
      chk("t3_addr_b0", 64'(bank_addr_o[0 +: 10]), 64'('h40 + k));
      chk("t3_addr_b3", 64'(bank_addr_o[30 +: 10]), 64'('h50 + k));
      tick();
    end
    reb = '1; rlast = '0;

    // 4: gaps inside a burst
    request(0, 2);
    beat(0, 2, 'h20, 1'b0);
    @(negedge clk);
    chk("t4_gap1", 64'(bank_reb_o[2]), 64'd1);
    tick();
    @(negedge clk);
    chk("t4_gap2", 64'(bank_reb_o[2]), 64'd1);
    chk("t4_gap_rvalid", 64'(rvalid_o[0]), 64'd0);
    tick();
    beat(0, 2, 'h21, 1'b0);
    beat(0, 2, 'h22, 1'b1);

    // 5: reset in the middle of a burst
    request(1, 1);
    beat(1, 1, 'h60, 1'b0);
    beat(1, 1, 'h61, 1'b0);
    rst = 1'b1;
    reb[1] = 1'b0; addr[10 +: 10] = 10'h62;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ack", 64'(ack_o), 64'd0);
    chk("t5_rvalid", 64'(rvalid_o), 64'd0);
    chk("t5_bank_reb", 64'(bank_reb_o), 64'hF);
    tick();
    reb[1] = 1'b1;
    request(1, 1);
    beat(1, 1, 'h63, 1'b1);

    // 6: non-owner strobes on a locked bank are ignored
    request(1, 1);
    reb[2] = 1'b0; addr[20 +: 10] = 10'h3FF; rid[4 +: 2] = 2'd1;
    @(negedge clk);
    chk("t6_gap_reb", 64'(bank_reb_o[1]), 64'd1);
    tick();
    beat(1, 1, 'h70, 1'b0);
    beat(1, 1, 'h71, 1'b1);
    @(negedge clk);
    chk("t6_rvalid2", 64'(rvalid_o[2]), 64'd0);
    chk("t6_rvalid1", 64'(rvalid_o[1]), 64'd1);
    tick();
    reb[2] = 1'b1;

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
